// File: rtl/branch_predict_unit.sv
// branch_predict_unit: N/Z/V flag file, PC-indexed saturating-counter predictors and registered resolve stage; BRANCH_STATS_EN adds branch/mispredict counters
module branch_predict_unit #(
  parameter int ADDR_W = 16,
  parameter int BHT_DEPTH = 16,
  parameter int CTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        flag_we,
  input  logic [2:0]        flag_in,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  input  logic              res_vld,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [2:0]        res_cond,
  input  logic              res_uncond_ok,
  input  logic              res_pred,
`ifdef BRANCH_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispred,
`endif
  output logic              br_taken,
  output logic              br_mispredict,
  output logic              out_vld
);
  localparam int IW = $clog2(BHT_DEPTH);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  logic [2:0]       flags;
  logic [CTR_W-1:0] bht [BHT_DEPTH];
  logic [IW-1:0]    fi, ri;
  logic [7:0]       ct;
  logic             outcome, miss;
  logic [CTR_W-1:0] cur, nxt;
  logic             unused_pc;
  assign fi = fetch_pc[IW-1:0];
  assign ri = res_pc[IW-1:0];
  assign unused_pc = ^{fetch_pc[ADDR_W-1:IW], res_pc[ADDR_W-1:IW]};
  assign ct = {1'b1, flags[0], flags[2] | flags[1], flags[1] | ~flags[2],
               flags[2], ~flags[1] & ~flags[2], flags[1], ~flags[1]};
  assign outcome = res_uncond_ok & ct[res_cond];
  assign miss = outcome ^ res_pred;
  assign cur = bht[ri];
  assign nxt = outcome ? (&cur ? cur : cur + 1'b1) : (|cur ? cur - 1'b1 : cur);
  assign pred_taken = bht[fi][CTR_W-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
      br_taken <= 1'b0;
      br_mispredict <= 1'b0;
      out_vld <= 1'b0;
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else begin
      flags <= (flags & ~flag_we) | (flag_in & flag_we);
      out_vld <= res_vld;
      br_mispredict <= res_vld & miss;
      if (res_vld) begin
        br_taken <= outcome;
        bht[ri] <= nxt;
      end
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred <= '0;
    end else if (stat_clr) begin
      stat_branches <= '0;
      stat_mispred <= '0;
    end else if (res_vld) begin
      stat_branches <= &stat_branches ? stat_branches : stat_branches + 16'd1;
      stat_mispred <= (miss && !(&stat_mispred)) ? stat_mispred + 16'd1 : stat_mispred;
    end
  end
`endif
endmodule
